ksa_swap_fsm: RTL and testbench
===============================

# ksa_swap_fsm

Key-scheduling stage of the RC4 decryption datapath. It runs immediately after the s_mem populate counter has loaded s_mem[i] = i and been started from that counter's finish pulse. For i = 0..255 it computes j = j + s[i] + key[i mod KEY_BYTES] and swaps s[i] with s[j] in place in s_mem. It owns the s_mem port for the whole run and pulses finish for the downstream PRGA/decrypt stage.

## Interface
- KEY_BYTES, 3: secret key length in bytes; byte 0 is the most significant byte of secret_key.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; one clock; clears all state.
- start  input  1  level-sampled only in IDLE; begins a run.
- secret_key  input  KEY_BYTES*8  key; must be held stable from start until finish.
- q  input  8  s_mem read data; valid in the cycle after address is registered by the RAM.
- address  output  8  s_mem address.
- data  output  8  s_mem write data.
- wren  output  1  s_mem write enable.
- busy  output  1  high in every state except IDLE.
- finish  output  1  one-cycle completion pulse.

## Operation
- Internal registers:
  - i[7:0], j[7:0], si[7:0], sj[7:0].
  - k: key index 0..KEY_BYTES-1, wraps to 0 when i increments; no divider.
- States: IDLE, READ_SI, WAIT_SI, LATCH_SI, READ_SJ, WAIT_SJ, LATCH_SJ, WRITE_I, WRITE_J, NEXT_I, DONE. Each state lasts exactly one cycle.
- IDLE:
  - i, j, k cleared.
  - If start=1, go to READ_SI; otherwise stay.
- READ_SI / WAIT_SI / LATCH_SI:
  - address=i throughout.
  - At the end of LATCH_SI: si<=q and j<=j+q+key_byte[k].
- READ_SJ / WAIT_SJ / LATCH_SJ:
  - address=j (the updated j) throughout.
  - At the end of LATCH_SJ: sj<=q.
- WRITE_I: address=i, data=sj, wren=1.
- WRITE_J: address=j, data=si, wren=1.
- NEXT_I:
  - If i==255, go to DONE.
  - Otherwise i<=i+1, k<=(k==KEY_BYTES-1)?0:k+1, and go to READ_SI.
- DONE: finish=1; return to IDLE.
- Arithmetic: all 8-bit, wrapping modulo 256; carries discarded.
- Case i==j: both writes target the same address with the same value; the final contents are unchanged.
- start while busy is ignored.
- start held high through DONE starts a new run after exactly one IDLE cycle.
- Outputs in states other than those listed above: address=0, data=0, wren=0.

## Timing
- Reset values: address=0, data=0, wren=0, busy=0, finish=0, state=IDLE, i=j=k=si=sj=0.
- reset asserted mid-run: all outputs take their reset values in the cycle after the sampling edge, including wren=0. No finish is issued.
- s_mem contents after a mid-run reset are undefined; the populate stage must re-run before the next start.
- Run timing, with start sampled at edge E0:
  - Iteration n occupies cycles 9n+1 .. 9n+9.
  - finish is high for exactly cycle 2305 after E0 (256×9+1).
  - busy is high for cycles 1..2305.
- wren is high for exactly 512 cycles per run, never on two consecutive iterations' boundary states, and never in IDLE or DONE.
- Read latency assumed from s_mem: 1 clock (registered address, unregistered q). q is sampled two edges after address is first driven.

## Configuration
- KSA_DEBUG_EN defined: adds output ports dbg_i[7:0] and dbg_j[7:0], driven directly from the i and j registers (reset value 0), for SignalTap/bench observation.
- KSA_DEBUG_EN undefined: these ports do not exist. All other behaviour and timing are identical in both builds.

## Test plan
- **Identity memory, secret_key=24'h000249, start pulse:**
  - Iteration 0 writes address 0, data 0 twice.
  - Iteration 1 computes j=3 and writes (address 1, data 3) then (address 3, data 1).
  - Final s_mem matches a software RC4 KSA model.
- **Latency:** start at E0 → finish high only in cycle 2305, busy high in cycles 1..2305, and exactly 512 cycles with wren=1.
- **Wrap-around, secret_key=24'hFFFFFF:**
  - j wraps modulo 256 on the first iteration (j=0+0+FF=FF) and writes (address 0, data FF), (address FF, data 0).
  - Final memory matches the model.
- **Reset at cycle 1000 of a run:** wren=0, busy=0, address=0 from the next cycle; no finish. After re-populate and restart, the run completes with correct memory.
- **start handling:**
  - start pulsed at cycle 500 of a run has no effect; finish still occurs at cycle 2305.
  - start held high continuously gives back-to-back runs separated by one IDLE cycle.
- **KSA_DEBUG_EN build:** dbg_i=1 and dbg_j=3 during iteration 1 of the first scenario.

Source files
------------

// File: rtl/ksa_swap_fsm.sv
// ksa_swap_fsm: RC4 key-scheduling stage. Walks i = 0..255 over s_mem,
// computes j = j + s[i] + key[i mod KEY_BYTES] and swaps s[i] with s[j].
// Each iteration takes nine one-cycle states. finish pulses once per run.
// Optional build macro: KSA_DEBUG_EN adds dbg_i/dbg_j observation ports.
module ksa_swap_fsm #(
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  input  logic [7:0]             q,
  output logic [7:0]             address,
  output logic [7:0]             data,
  output logic                   wren,
  output logic                   busy,
  output logic                   finish
`ifdef KSA_DEBUG_EN
  ,
  output logic [7:0]             dbg_i,
  output logic [7:0]             dbg_j
`endif
);

  localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {
    IDLE,
    READ_SI,
    WAIT_SI,
    LATCH_SI,
    READ_SJ,
    WAIT_SJ,
    LATCH_SJ,
    WRITE_I,
    WRITE_J,
    NEXT_I,
    DONE
  } state_t;

  state_t        state;
  logic [7:0]    i;
  logic [7:0]    j;
  logic [7:0]    si;
  logic [7:0]    sj;
  logic [KW-1:0] k;
  logic [7:0]    key_byte;
  logic [7:0]    j_new;

  // Key byte select; byte 0 is the most significant byte of secret_key.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (k == KW'(b)) key_byte = secret_key[(KEY_BYTES-1-b)*8 +: 8];
    end
  end

  // Updated j from the s[i] read data, wrapping modulo 256.
  always_comb begin
    j_new = 8'(j + q + key_byte);
  end

  // Sequencer; every output register is loaded with the value for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      si      <= '0;
      sj      <= '0;
      address <= '0;
      data    <= '0;
      wren    <= 1'b0;
      busy    <= 1'b0;
      finish  <= 1'b0;
    end else begin
      address <= '0;
      data    <= '0;
      wren    <= 1'b0;
      finish  <= 1'b0;
      busy    <= 1'b1;
      case (state)
        IDLE: begin
          i <= '0;
          j <= '0;
          k <= '0;
          busy <= start;
          if (start) state <= READ_SI;
        end
        READ_SI: begin
          state   <= WAIT_SI;
          address <= i;
        end
        WAIT_SI: begin
          state   <= LATCH_SI;
          address <= i;
        end
        LATCH_SI: begin
          si      <= q;
          j       <= j_new;
          state   <= READ_SJ;
          address <= j_new;
        end
        READ_SJ: begin
          state   <= WAIT_SJ;
          address <= j;
        end
        WAIT_SJ: begin
          state   <= LATCH_SJ;
          address <= j;
        end
        LATCH_SJ: begin
          sj      <= q;
          state   <= WRITE_I;
          address <= i;
          data    <= q;
          wren    <= 1'b1;
        end
        WRITE_I: begin
          state   <= WRITE_J;
          address <= j;
          // When i == j the location already holds sj (== si), so the value is unchanged.
          data    <= (i == j) ? sj : si;
          wren    <= 1'b1;
        end
        WRITE_J: begin
          state <= NEXT_I;
        end
        NEXT_I: begin
          if (i == 8'hFF) begin
            state  <= DONE;
            finish <= 1'b1;
          end else begin
            i       <= 8'(i + 8'd1);
            k       <= (k == KW'(KEY_BYTES-1)) ? '0 : KW'(k + KW'(1));
            state   <= READ_SI;
            address <= 8'(i + 8'd1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef KSA_DEBUG_EN
  assign dbg_i = i;
  assign dbg_j = j;
`endif

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// Bench for ksa_swap_fsm: table of keys with hand-derived first writes,
// write scoreboard fed by a software RC4 KSA model, plus latency, start
// handling and mid-run reset sequences.
module tb_ksa_swap_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  q;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        wren;
  logic        busy;
  logic        finish;
`ifdef KSA_DEBUG_EN
  logic [7:0]  dbg_i;
  logic [7:0]  dbg_j;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ksa_swap_fsm #(.KEY_BYTES(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .secret_key (secret_key),
    .q          (q),
    .address    (address),
    .data       (data),
    .wren       (wren),
    .busy       (busy),
    .finish     (finish)
`ifdef KSA_DEBUG_EN
    ,
    .dbg_i      (dbg_i),
    .dbg_j      (dbg_j)
`endif
  );

  // s_mem model: registered address, 1-cycle read latency, populate on request.
  logic [7:0] mem [256];
  logic       pop_req = 1'b0;
  always @(posedge clk) begin
    if (pop_req) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
    end else if (wren) begin
      mem[address] <= data;
    end
    q <= mem[address];
  end

  typedef struct {
    logic [23:0] key;
    logic [15:0] wr [4];
  } vec_t;

  vec_t        vec [4];
  logic [15:0] sb [$];
  logic [7:0]  exp_mem [256];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic populate();
    @(negedge clk);
    pop_req = 1'b1;
    @(negedge clk);
    pop_req = 1'b0;
  endtask

  // Software RC4 KSA on identity memory; pushes expected writes, fills exp_mem.
  task automatic ksa_model(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] jj;
    logic [7:0] t;
    for (int a = 0; a < 256; a++) s[a] = 8'(a);
    jj = 8'h00;
    for (int ii = 0; ii < 256; ii++) begin
      jj = 8'(jj + s[ii] + key[(2 - (ii % 3))*8 +: 8]);
      sb.push_back({8'(ii), s[jj]});
      sb.push_back({jj, s[ii]});
      t = s[ii];
      s[ii] = s[jj];
      s[jj] = t;
    end
    for (int a = 0; a < 256; a++) exp_mem[a] = s[a];
  endtask

  task automatic do_run(input int v, input bit pulse_mid, input bit rst_mid, input bit hold);
    int         wr_cnt = 0;
    int         busy_cnt = 0;
    int         busy_last = 0;
    int         fin_cnt = 0;
    int         fin_cyc = 0;
    int         wi = 0;
    int         bad = 0;
    logic       b2306 = 1'b1;
    logic       b2307 = 1'b0;
    logic [15:0] w;
    secret_key = vec[v].key;
    sb.delete();
    populate();
    ksa_model(vec[v].key);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 2310; n++) begin
      @(negedge clk);
      if (busy) begin busy_cnt++; busy_last = n; end
      if (n == 2306) b2306 = busy;
      if (n == 2307) b2307 = busy;
      if (finish) begin fin_cnt++; fin_cyc = n; end
      if (wren && n <= 2305) begin
        wr_cnt++;
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          w = sb.pop_front();
          if (wi < 4) chk($sformatf("v%0d_wr%0d", v, wi), int'({address, data}), int'(vec[v].wr[wi]));
          chk("sb_write", int'({address, data}), int'(w));
          wi++;
        end
      end
      if (n == 1) chk("first_addr", int'(address), 0);
`ifdef KSA_DEBUG_EN
      if (n == 16 && v == 0) begin
        chk("dbg_i", int'(dbg_i), 1);
        chk("dbg_j", int'(dbg_j), 3);
      end
`endif
      if (n == 1 && !hold) start = 1'b0;
      if (pulse_mid && n == 500) start = 1'b1;
      if (pulse_mid && n == 501) start = 1'b0;
      if (rst_mid && n == 1000) reset = 1'b1;
      if (rst_mid && n == 1001) begin
        chk("rst_wren", int'(wren), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_addr", int'(address), 0);
        chk("rst_data", int'(data), 0);
        reset = 1'b0;
      end
      if (rst_mid && n == 1100) break;
    end
    if (rst_mid) begin
      chk("no_finish_after_reset", fin_cnt, 0);
      chk("busy_last_before_reset", busy_last, 1000);
      sb.delete();
      return;
    end
    chk("finish_count", fin_cnt, 1);
    chk("finish_cycle", fin_cyc, 2305);
    chk("wren_count", wr_cnt, 512);
    chk("sb_empty", sb.size(), 0);
    if (hold) begin
      chk("hold_idle_gap", int'(b2306), 0);
      chk("hold_restart", int'(b2307), 1);
    end else begin
      chk("busy_count", busy_cnt, 2305);
      chk("busy_last", busy_last, 2305);
    end
    for (int a = 0; a < 256; a++) if (mem[a] !== exp_mem[a]) bad++;
    chk($sformatf("v%0d_final_mem_bad", v), bad, 0);
  endtask

  initial begin
    vec[0].key = 24'h000249; vec[0].wr = '{16'h0000, 16'h0000, 16'h0103, 16'h0301};
    vec[1].key = 24'hFFFFFF; vec[1].wr = '{16'h00FF, 16'hFF00, 16'h0100, 16'hFF01};
    vec[2].key = 24'h010203; vec[2].wr = '{16'h0001, 16'h0100, 16'h0103, 16'h0300};
    vec[3].key = 24'h123456; vec[3].wr = '{16'h0012, 16'h1200, 16'h0147, 16'h4701};

    reset = 1'b1;
    start = 1'b0;
    secret_key = '0;
    repeat (2) @(negedge clk);
    chk("reset_addr", int'(address), 0);
    chk("reset_data", int'(data), 0);
    chk("reset_wren", int'(wren), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_finish", int'(finish), 0);
    reset = 1'b0;

    for (int v = 0; v < 4; v++) do_run(v, 1'b0, 1'b0, 1'b0);

    do_run(0, 1'b1, 1'b0, 1'b0);

    do_run(1, 1'b0, 1'b1, 1'b0);
    do_run(1, 1'b0, 1'b0, 1'b0);

    do_run(2, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("post_hold_reset_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
